// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the square-root job scheduler and its arbiter.
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int SQRT_CORE_LATENCY = 17;
    localparam logic [31:0] RESP_ERR_ROOT = 32'h0000_0000;

    // Owner-index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after rr_ptr, modulo NREQ.
module rr_arbiter
    import sqrt_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    localparam int PW = IDW + 1;
    localparam logic [PW-1:0] NREQ_W = PW'(NREQ);

    logic [PW-1:0]  probe_s;
    logic [IDW-1:0] cand_s;
    logic           hit_s;
    logic           found_s;

    // Walk the requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        probe_s   = '0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            probe_s   = {1'b0, rr_ptr} + PW'(k);
            probe_s   = (probe_s >= NREQ_W) ? (probe_s - NREQ_W) : probe_s;
            cand_s    = probe_s[IDW-1:0];
            hit_s     = !found_s && req_valid[cand_s];
            grant[cand_s] = grant[cand_s] | hit_s;
            grant_idx = hit_s ? cand_s : grant_idx;
            found_s   = found_s | hit_s;
        end
    end

    assign any_grant = found_s;

endmodule

// File: rtl/sqrt_job_scheduler.sv
// Shares one SqrtCore among NREQ requesters: round-robin accept, one-shot start,
// result capture with a saturating watchdog, and a per-owner response handshake.
module sqrt_job_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int IDW            = idx_width(NREQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_radicand,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_root,
    output logic                 resp_err,
    output logic                 core_start,
    output logic [31:0]          core_radicand,
    input  logic [31:0]          core_root,
    input  logic                 core_busy,
    input  logic                 core_done,
    output logic [IDW-1:0]       owner_id,
    output logic                 active,
    output logic [15:0]          job_count
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LIMIT = WDW'(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WDOG_SAT   = '1;
    localparam logic [IDW-1:0] LAST_IDX   = IDW'(NREQ - 1);

    sched_state_t    state_r;
    sched_state_t    state_n;

    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  owner_id_r;
    logic [31:0]     core_radicand_r;
    logic [31:0]     resp_root_r;
    logic            resp_err_r;
    logic [NREQ-1:0] resp_valid_r;
    logic            core_start_r;
    logic            active_r;
    logic [15:0]     job_count_r;
    logic [WDW-1:0]  wdog_r;

    logic [WDW-1:0]  wdog_next_s;
    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  grant_idx_s;
    logic            any_grant_s;
    logic [31:0]     pick_radicand_s;
    logic [NREQ-1:0] owner_onehot_s;
    logic            accept_s;
    logic            start_s;
    logic            take_done_s;
    logic            take_timeout_s;
    logic            resp_hs_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    // Select the winning requester's radicand with an AND-OR mux on the one-hot grant.
    always_comb begin
        pick_radicand_s = 32'h0000_0000;
        for (int i = 0; i < NREQ; i++) begin
            pick_radicand_s = pick_radicand_s | (req_radicand[32*i +: 32] & {32{grant_s[i]}});
        end
    end

    // Decode the current owner into a one-hot response vector.
    always_comb begin
        owner_onehot_s = '0;
        owner_onehot_s[owner_id_r] = 1'b1;
    end

    assign wdog_next_s = (wdog_r == WDOG_SAT) ? wdog_r : (wdog_r + WDW'(1));

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_n        = state_r;
        accept_s       = 1'b0;
        start_s        = 1'b0;
        take_done_s    = 1'b0;
        take_timeout_s = 1'b0;
        resp_hs_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_grant_s) begin
                    accept_s = 1'b1;
                    state_n  = ISSUE;
                end else begin
                    state_n  = IDLE;
                end
            end
            ISSUE: begin
                if (!core_busy && !core_done) begin
                    start_s = 1'b1;
                    state_n = WAIT;
                end else begin
                    state_n = ISSUE;
                end
            end
            WAIT: begin
                // A done arriving on the timeout cycle still yields a good result.
                if (core_done) begin
                    take_done_s    = 1'b1;
                    state_n        = RESP;
                end else if (wdog_next_s >= WDOG_LIMIT) begin
                    take_timeout_s = 1'b1;
                    state_n        = RESP;
                end else begin
                    state_n        = WAIT;
                end
            end
            RESP: begin
                if (resp_ready[owner_id_r]) begin
                    resp_hs_s = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n   = RESP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Job datapath: latched request, start pulse, watchdog, result and bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r        <= '0;
            owner_id_r      <= '0;
            core_radicand_r <= 32'h0000_0000;
            resp_root_r     <= 32'h0000_0000;
            resp_err_r      <= 1'b0;
            resp_valid_r    <= '0;
            core_start_r    <= 1'b0;
            active_r        <= 1'b0;
            job_count_r     <= 16'h0000;
            wdog_r          <= '0;
        end else begin
            core_start_r <= start_s;

            if (accept_s) begin
                owner_id_r      <= grant_idx_s;
                core_radicand_r <= pick_radicand_s;
                active_r        <= 1'b1;
            end

            if (start_s) begin
                wdog_r <= '0;
            end else if (state_r == WAIT) begin
                wdog_r <= wdog_next_s;
            end

            if (take_done_s) begin
                resp_root_r  <= core_root;
                resp_err_r   <= 1'b0;
                resp_valid_r <= owner_onehot_s;
            end else if (take_timeout_s) begin
                resp_root_r  <= RESP_ERR_ROOT;
                resp_err_r   <= 1'b1;
                resp_valid_r <= owner_onehot_s;
            end

            if (resp_hs_s) begin
                resp_valid_r <= '0;
                active_r     <= 1'b0;
                job_count_r  <= job_count_r + 16'd1;
                rr_ptr_r     <= (owner_id_r == LAST_IDX) ? '0 : (owner_id_r + IDW'(1));
            end
        end
    end

    // Only the arbiter's winner sees ready, and only while idle and out of reset.
    assign req_ready     = ((state_r == IDLE) && !reset) ? grant_s : '0;
    assign resp_valid    = resp_valid_r;
    assign resp_root     = resp_root_r;
    assign resp_err      = resp_err_r;
    assign core_start    = core_start_r;
    assign core_radicand = core_radicand_r;
    assign owner_id      = owner_id_r;
    assign active        = active_r;
    assign job_count     = job_count_r;

endmodule

// File: tb/tb_sqrt_job_scheduler.sv
// Randomized bench for sqrt_job_scheduler with a behavioural SqrtCore stub and a
// transaction-level reference (round-robin pick, integer sqrt, fixed latencies).
module tb_sqrt_job_scheduler;
    import sqrt_sched_pkg::*;

    localparam int NREQ = 3;
    localparam int IDW  = idx_width(NREQ);
    localparam int TMO  = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_radicand;
    logic [NREQ-1:0]     resp_valid;
    logic [NREQ-1:0]     resp_ready;
    logic [31:0]         resp_root;
    logic                resp_err;
    logic                core_start;
    logic [31:0]         core_radicand;
    logic [31:0]         core_root;
    logic                core_busy;
    logic                core_done;
    logic [IDW-1:0]      owner_id;
    logic                active;
    logic [15:0]         job_count;

    sqrt_job_scheduler #(
        .NREQ           (NREQ),
        .IDW            (IDW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_radicand  (req_radicand),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_root     (resp_root),
        .resp_err      (resp_err),
        .core_start    (core_start),
        .core_radicand (core_radicand),
        .core_root     (core_root),
        .core_busy     (core_busy),
        .core_done     (core_done),
        .owner_id      (owner_id),
        .active        (active),
        .job_count     (job_count)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] isqrt(input logic [31:0] x);
        longint r;
        longint t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r + (longint'(1) << b);
            if (t * t <= longint'({32'h0000_0000, x})) r = t;
        end
        return r[31:0];
    endfunction

    // Behavioural SqrtCore: 16 compute cycles then a one-cycle done.
    logic        stub_busy;
    logic        stub_done;
    logic [31:0] stub_root;
    logic [31:0] stub_rad;
    int          stub_cnt;
    logic        force_busy;
    logic        hang;

    assign core_busy = stub_busy | force_busy;
    assign core_done = stub_done;
    assign core_root = stub_root;

    always @(posedge clk) begin
        if (reset) begin
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
            stub_root <= 32'h0;
            stub_rad  <= 32'h0;
            stub_cnt  <= 0;
        end else begin
            stub_done <= 1'b0;
            if (stub_busy) begin
                if (stub_cnt == SQRT_CORE_LATENCY - 2) begin
                    stub_busy <= 1'b0;
                    stub_done <= !hang;
                    stub_root <= isqrt(stub_rad);
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end else if (core_start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 0;
                stub_rad  <= core_radicand;
            end
        end
    end

    // Reference model state: pending requests, round-robin pointer, completed jobs.
    logic        pend_valid [NREQ];
    logic [31:0] pend_rad   [NREQ];
    int          mptr;
    logic [15:0] mjobs;

    function automatic int model_winner();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mptr + k) % NREQ;
            if (pend_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend_valid[i];
            req_radicand[32*i +: 32] = pend_rad[i];
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_req_ready"},     req_ready, 0);
        check_eq({pfx, "_resp_valid"},    resp_valid, 0);
        check_eq({pfx, "_resp_root"},     resp_root, 0);
        check_eq({pfx, "_resp_err"},      resp_err, 0);
        check_eq({pfx, "_core_start"},    core_start, 0);
        check_eq({pfx, "_core_radicand"}, core_radicand, 0);
        check_eq({pfx, "_owner_id"},      owner_id, 0);
        check_eq({pfx, "_active"},        active, 0);
        check_eq({pfx, "_job_count"},     job_count, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) pend_valid[i] = 1'b0;
        drive_reqs();
        resp_ready = '0;
        force_busy = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        mptr  = 0;
        mjobs = 16'h0;
    endtask

    // One complete job: accept, start, result, optional back-pressure, response handshake.
    task automatic serve_one(input int bp, input int stall, input bit hang_mode,
                             input bit keep, output int won);
        int              w;
        int              t;
        int              exp_lat;
        logic [31:0]     rad;
        logic [31:0]     exp_root;
        logic [NREQ-1:0] oh;
        w   = model_winner();
        won = w;
        if (w < 0) begin
            check_eq("no_pending_request", 0, 1);
            return;
        end
        rad      = pend_rad[w];
        exp_root = hang_mode ? 32'h0 : isqrt(rad);
        exp_lat  = hang_mode ? (stall + 1 + TMO) : (stall + 19);
        oh       = '0;
        oh[w]    = 1'b1;
        hang       = hang_mode;
        force_busy = (stall > 0);
        drive_reqs();
        #1;
        check_eq("req_ready_grant", req_ready, oh);
        check_eq("idle_inactive", active, 0);

        tick();
        t = 0;
        if (!keep) pend_valid[w] = 1'b0;
        drive_reqs();
        force_busy = (t < stall);
        check_eq("owner_id", owner_id, w);
        check_eq("core_radicand", core_radicand, rad);
        check_eq("active_busy", active, 1);
        check_eq("ready_low_issue", req_ready, 0);

        while (!core_start && t < 200) begin
            tick();
            t++;
            force_busy = (t < stall);
        end
        check_eq("start_latency", t, stall + 1);
        tick();
        t++;
        force_busy = 1'b0;
        check_eq("start_single_pulse", core_start, 0);

        while (resp_valid == '0 && t < 400) begin
            tick();
            t++;
        end
        check_eq("resp_latency", t, exp_lat);
        check_eq("resp_valid_owner", resp_valid, oh);
        check_eq("resp_root", resp_root, exp_root);
        check_eq("resp_err", resp_err, hang_mode);
        check_eq("radicand_held", core_radicand, rad);

        for (int k = 0; k < bp; k++) begin
            resp_ready = NREQ'($urandom) & ~oh;
            tick();
            check_eq("bp_resp_valid", resp_valid, oh);
            check_eq("bp_root_stable", resp_root, exp_root);
            check_eq("bp_req_ready", req_ready, 0);
            check_eq("bp_no_start", core_start, 0);
        end

        resp_ready = oh;
        tick();
        resp_ready = '0;
        mptr  = (w + 1) % NREQ;
        mjobs = mjobs + 16'd1;
        check_eq("resp_dropped", resp_valid, 0);
        check_eq("job_count", job_count, mjobs);
        check_eq("idle_after_resp", active, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int          won;
        int          sel;
        int          k;
        logic        seen;
        logic        any;
        logic [31:0] ext [4];
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        req_valid    = '0;
        req_radicand = '0;
        resp_ready   = '0;
        force_busy   = 1'b0;
        hang         = 1'b0;
        mptr         = 0;
        mjobs        = 16'h0;
        for (int i = 0; i < NREQ; i++) begin
            pend_valid[i] = 1'b0;
            pend_rad[i]   = 32'h0;
        end
        do_reset();

        pend_valid[0] = 1'b1; pend_rad[0] = 32'd144;
        serve_one(0, 0, 1'b0, 1'b0, won);
        check_eq("single_job_count", job_count, 1);

        do_reset();
        pend_valid[0] = 1'b1; pend_rad[0] = 32'd100;
        pend_valid[1] = 1'b1; pend_rad[1] = 32'd81;
        serve_one(0, 0, 1'b0, 1'b1, won); check_eq("contend_order0", won, 0);
        serve_one(0, 0, 1'b0, 1'b1, won); check_eq("contend_order1", won, 1);
        serve_one(0, 0, 1'b0, 1'b1, won); check_eq("contend_order2", won, 0);
        for (int i = 0; i < NREQ; i++) pend_valid[i] = 1'b0;

        do_reset();
        pend_valid[0] = 1'b1; pend_rad[0] = 32'h1234_5678;
        serve_one(5, 0, 1'b0, 1'b1, won);
        pend_valid[0] = 1'b0;

        ext[0] = 32'hFFFF_FFFF; ext[1] = 32'h0; ext[2] = 32'h1; ext[3] = 32'h4000_0000;
        for (int i = 0; i < 4; i++) begin
            pend_valid[0] = 1'b1; pend_rad[0] = ext[i];
            serve_one(0, 0, 1'b0, 1'b0, won);
        end

        pend_valid[1] = 1'b1; pend_rad[1] = 32'd625;
        serve_one(1, 0, 1'b1, 1'b0, won);

        pend_valid[2] = 1'b1; pend_rad[2] = 32'd10000;
        serve_one(0, 4, 1'b0, 1'b0, won);

        for (int j = 0; j < 40; j++) begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_valid[i] && $urandom_range(0, 1) == 1) begin
                    pend_valid[i] = 1'b1;
                    sel = $urandom_range(0, 3);
                    k   = $urandom_range(1, 65535);
                    case (sel)
                        0:       pend_rad[i] = $urandom;
                        1:       pend_rad[i] = $urandom_range(0, 255);
                        2:       pend_rad[i] = 32'(k) * 32'(k);
                        default: pend_rad[i] = 32'(k) * 32'(k) - 32'd1;
                    endcase
                end
                any = any | pend_valid[i];
            end
            if (!any) begin
                k = $urandom_range(0, NREQ - 1);
                pend_valid[k] = 1'b1;
                pend_rad[k]   = $urandom;
            end
            serve_one($urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b0, won);
        end
        for (int i = 0; i < NREQ; i++) pend_valid[i] = 1'b0;

        // Reset while a job is in WAIT: no response, pointer back to 0.
        pend_valid[1] = 1'b1; pend_rad[1] = 32'd1000;
        drive_reqs();
        tick();
        pend_valid[1] = 1'b0;
        drive_reqs();
        repeat (8) tick();
        check_eq("midjob_active", active, 1);
        reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        mptr  = 0;
        mjobs = 16'h0;
        seen  = 1'b0;
        repeat (25) begin
            tick();
            seen = seen | (|resp_valid);
        end
        check_eq("no_resp_after_reset", seen, 0);
        pend_valid[0] = 1'b1; pend_rad[0] = 32'd500;
        pend_valid[1] = 1'b1; pend_rad[1] = 32'd49;
        serve_one(0, 0, 1'b0, 1'b0, won); check_eq("post_reset_ptr", won, 0);
        serve_one(0, 0, 1'b0, 1'b0, won); check_eq("post_reset_req1", won, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt_job_scheduler.md
# sqrt_job_scheduler

Round-robin job scheduler that shares one `SqrtCore` among `NREQ` requesters, such as the CPU MMIO port and a DMA/streaming master. It accepts radicands over per-requester valid/ready handshakes and issues each job to the core with a one-cycle start pulse. It captures the root on `done` and returns it to the owning requester through a per-requester response handshake. A watchdog converts a hung core into an error response.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..8)
- `IDW`, `$clog2(NREQ)` (min 1), owner-index width
- `TIMEOUT_CYCLES`, 64, max cycles in WAIT before an error response

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high; clears all state
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  one-hot acceptance; a handshake completes when valid&ready
- `req_radicand`  in  NREQ*32  flattened; requester i occupies bits [32i+31:32i]
- `resp_valid`  out  NREQ  one-hot result available to the owner
- `resp_ready`  in  NREQ  owner consumes the response
- `resp_root`  out  32  result; 0 on error; meaningful only while a `resp_valid` bit is high
- `resp_err`  out  1  timeout flag, qualified by `resp_valid`
- `core_start`  out  1  one-cycle start pulse to `SqrtCore`
- `core_radicand`  out  32  radicand held stable from ISSUE through WAIT
- `core_root`, `core_busy`, `core_done`  in  32/1/1  driven by `SqrtCore`
- `owner_id`  out  IDW  index of the current job owner
- `active`  out  1  high in any state other than IDLE
- `job_count`  out  16  completed responses (including errors), wraps at 0xFFFF→0

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - The arbiter picks the first `req_valid` bit, searching from `rr_ptr` upward modulo NREQ.
  - `req_ready` is driven high combinationally for that one winner only.
  - On the handshake, the block latches the radicand and `owner_id`, then moves to ISSUE.
  - With no `req_valid`, it stays in IDLE.
- ISSUE:
  - If `!core_busy && !core_done`, it asserts `core_start` for exactly one cycle, clears the watchdog and moves to WAIT.
  - Otherwise it holds in ISSUE with `core_start`=0.
- WAIT:
  - The watchdog increments each cycle.
  - On `core_done`, it captures `core_root` into `resp_root`, sets `resp_err`=0 and moves to RESP.
  - If the watchdog reaches `TIMEOUT_CYCLES` with no done, it sets `resp_root`=0 and `resp_err`=1 and moves to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `resp_valid[owner_id]` is held high; `resp_root` and `resp_err` are stable until `resp_ready[owner_id]`.
  - On that handshake: `rr_ptr` ← (owner_id+1) mod NREQ, `job_count` increments, and the state returns to IDLE.
  - `resp_ready` bits of non-owners are ignored.
- `req_ready` is all zero outside IDLE. One job is in flight at a time; there is no queueing.
- Starvation bound: a requester holding `req_valid` is served within NREQ jobs.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `owner_id`=0, `req_ready`=0, `resp_valid`=0, `resp_root`=0, `resp_err`=0, `core_start`=0, `core_radicand`=0, `active`=0, `job_count`=0.
- `reset` must also reset `SqrtCore` in the same cycle.
- Reset mid-job: the in-flight job is dropped and no response is issued; the requester re-requests.
- Latency with the team's `SqrtCore` (16 COMPUTE cycles + 1 DONE cycle):
  - request handshake at cycle 0
  - `core_start` at cycle 1
  - `core_done` at cycle 18
  - `resp_valid` first high at cycle 19
  - Next accept is possible 1 cycle after the response handshake.
- `core_start` is registered, so it never glitches and is never high for two consecutive cycles.
- The watchdog is 7 bits wide (sized to `$clog2(TIMEOUT_CYCLES+1)`) and saturates.

## Structure
- Package `sqrt_sched_pkg`:
  - `sched_state_t` enum {IDLE, ISSUE, WAIT, RESP}
  - `SQRT_CORE_LATENCY` = 17
  - `RESP_ERR_ROOT` = 32'h0
- Sub-module `rr_arbiter`: combinational, takes `req_valid` and `rr_ptr`, outputs a one-hot grant plus an encoded index. It is also reusable for other shared accelerators.
- `SqrtCore` is instantiated by the parent, not inside this block.

## Test plan
- Single job: req0 radicand 144 → `core_start` at cycle 1, `resp_valid[0]` at cycle 19, root 12, err 0, `job_count`=1.
- Contention: after reset, req0=100 and req1=81 both held valid for three jobs → grant order 0, 1, 0; roots 10, 9, 10; `req_ready` always one-hot.
- Back-pressure: `resp_ready[0]` low for 5 cycles → `resp_valid[0]` and root stay stable, `req_ready`=0, no `core_start`; accept resumes 1 cycle after ready.
- Extremes: 0xFFFFFFFF → 65535; 0 → 0; 1 → 1; 0x40000000 → 32768.
- Timeout: core stub never asserts done → `resp_valid` high after 64 WAIT cycles, `resp_err`=1, root 0. A stub busy at ISSUE delays `core_start` until it goes idle.
- Reset during WAIT → all outputs at reset values the following cycle, `rr_ptr`=0, no response; a fresh req1 of 49 then returns 7.
